// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: opcode classes,
// branch function codes and the PC width.
package kgp_pkg;

  localparam int PC_W = 10;

  localparam logic [2:0] OP_BRANCH = 3'b011;

  localparam logic [3:0] FC_B    = 4'b0000;
  localparam logic [3:0] FC_BZ   = 4'b0001;
  localparam logic [3:0] FC_BNZ  = 4'b0010;
  localparam logic [3:0] FC_BCY  = 4'b0011;
  localparam logic [3:0] FC_BNCY = 4'b0100;
  localparam logic [3:0] FC_BS   = 4'b0101;
  localparam logic [3:0] FC_BNS  = 4'b0110;
  localparam logic [3:0] FC_BV   = 4'b0111;
  localparam logic [3:0] FC_BNV  = 4'b1000;
  localparam logic [3:0] FC_CALL = 4'b1001;
  localparam logic [3:0] FC_BLT  = 4'b1010;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition decode against
// the ALU status flags; reserved codes never take.
module branch_cond
  import kgp_pkg::*;
(
  input  logic [3:0] fcode,
  input  logic       carryFlag,
  input  logic       zFlag,
  input  logic       overflowFlag,
  input  logic       signFlag,
  output logic       taken,
  output logic       is_call
);

  always_comb begin
    taken   = 1'b0;
    is_call = 1'b0;
    unique case (1'b1)
      (fcode == FC_B):    taken = 1'b1;
      (fcode == FC_BZ):   taken = zFlag;
      (fcode == FC_BNZ):  taken = ~zFlag;
      (fcode == FC_BCY):  taken = carryFlag;
      (fcode == FC_BNCY): taken = ~carryFlag;
      (fcode == FC_BS):   taken = signFlag;
      (fcode == FC_BNS):  taken = ~signFlag;
      (fcode == FC_BV):   taken = overflowFlag;
      (fcode == FC_BNV):  taken = ~overflowFlag;
      (fcode == FC_CALL): begin
        taken   = 1'b1;
        is_call = 1'b1;
      end
      (fcode == FC_BLT):  taken = signFlag ^ overflowFlag;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch resolution: registered next PC,
// PC-select strobe and call link register.
module branch_unit
  import kgp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      opcode,
  input  logic [3:0]      fcode,
  input  logic [24:0]     label,
  input  logic            carryFlag,
  input  logic            zFlag,
  input  logic            overflowFlag,
  input  logic            signFlag,
  input  logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] exNPC,
  output logic            PCSrc,
  output logic [31:0]     ra
);

  logic            condTaken;
  logic            condCall;
  logic            isBranch;
  logic            taken;
  logic            doLink;
  logic [PC_W-1:0] pcPlus1;
  logic [PC_W-1:0] target;
  logic            unusedLabel;

  branch_cond uCond (
    .fcode        (fcode),
    .carryFlag    (carryFlag),
    .zFlag        (zFlag),
    .overflowFlag (overflowFlag),
    .signFlag     (signFlag),
    .taken        (condTaken),
    .is_call      (condCall)
  );

  // Only the low PC_W bits of the label form an absolute target.
  assign unusedLabel = ^label[24:PC_W];
  assign target      = label[PC_W-1:0];
  assign pcPlus1     = PC + 10'd1;
  assign isBranch    = (opcode == OP_BRANCH);
  assign taken       = isBranch & condTaken;
  assign doLink      = isBranch & condCall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exNPC <= '0;
      PCSrc <= 1'b0;
      ra    <= '0;
    end else begin
      PCSrc <= taken;
      exNPC <= taken ? target : pcPlus1;
      if (doLink)
        ra <= {22'b0, pcPlus1};
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: hand-computed vectors
// checked one cycle after each presented instruction.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  opcode;
  logic [3:0]  fcode;
  logic [24:0] label;
  logic        carryFlag, zFlag, overflowFlag, signFlag;
  logic [9:0]  PC;
  logic [9:0]  exNPC;
  logic        PCSrc;
  logic [31:0] ra;

  int nCmp = 0;
  int nBad = 0;

  branch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .fcode        (fcode),
    .label        (label),
    .carryFlag    (carryFlag),
    .zFlag        (zFlag),
    .overflowFlag (overflowFlag),
    .signFlag     (signFlag),
    .PC           (PC),
    .exNPC        (exNPC),
    .PCSrc        (PCSrc),
    .ra           (ra)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setIn(input logic [2:0] op,
                       input logic [3:0] fc,
                       input logic [24:0] lab,
                       input logic [9:0] pc,
                       input logic c, input logic z,
                       input logic v, input logic s);
    opcode = op; fcode = fc; label = lab; PC = pc;
    carryFlag = c; zFlag = z;
    overflowFlag = v; signFlag = s;
  endtask

  task automatic cyc(input logic [2:0] op,
                     input logic [3:0] fc,
                     input logic [24:0] lab,
                     input logic [9:0] pc,
                     input logic c, input logic z,
                     input logic v, input logic s);
    @(negedge clk);
    setIn(op, fc, lab, pc, c, z, v, s);
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag,
                      input logic src,
                      input logic [9:0] npc,
                      input logic [31:0] r);
    chk({tag, ".PCSrc"}, {31'b0, PCSrc}, {31'b0, src});
    chk({tag, ".exNPC"}, {22'b0, exNPC}, {22'b0, npc});
    chk({tag, ".ra"}, ra, r);
  endtask

  initial begin
    logic fl;
    logic expT;
    logic c, z, v, s;
    rst_n = 1'b0;
    setIn(3'b000, 4'd0, 25'd0, 10'd0, 0, 0, 0, 0);
    #2;
    outs("reset", 1'b0, 10'd0, 32'd0);
    @(posedge clk);
    #1;
    outs("resetHeld", 1'b0, 10'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(3'b011, 4'b1001, 25'd150, 10'd120, 0, 0, 1, 1);
    outs("call", 1'b1, 10'd150, 32'd121);

    cyc(3'b011, 4'b0000, 25'd150, 10'd0, 0, 0, 0, 0);
    outs("b", 1'b1, 10'd150, 32'd121);

    cyc(3'b011, 4'b1010, 25'd150, 10'd120, 0, 0, 1, 1);
    outs("bltSV11", 1'b0, 10'd121, 32'd121);

    cyc(3'b011, 4'b1010, 25'd150, 10'd120, 0, 0, 0, 1);
    outs("bltS1V0", 1'b1, 10'd150, 32'd121);

    cyc(3'b011, 4'b1010, 25'd150, 10'd120, 0, 0, 1, 0);
    outs("bltS0V1", 1'b1, 10'd150, 32'd121);

    // each code tested with its flag at 0 and 1, other flags opposite
    for (int f = 1; f <= 8; f++) begin
      for (int b = 0; b < 2; b++) begin
        fl = b[0];
        c = ~fl; z = ~fl; v = ~fl; s = ~fl;
        case (f)
          1, 2: z = fl;
          3, 4: c = fl;
          5, 6: s = fl;
          default: v = fl;
        endcase
        expT = f[0] ? fl : ~fl;
        cyc(3'b011, f[3:0], 25'd150, 10'd200, c, z, v, s);
        outs($sformatf("sweep f%0d fl%0d", f, b), expT,
             expT ? 10'd150 : 10'd201, 32'd121);
      end
    end

    cyc(3'b011, 4'b0000, {15'h7fff, 10'd77}, 10'd3, 0, 0, 0, 0);
    outs("labelHi", 1'b1, 10'd77, 32'd121);

    for (int f = 11; f <= 15; f++) begin
      cyc(3'b011, f[3:0], 25'd150, 10'd40, 1, 1, 1, 1);
      outs($sformatf("reserved f%0d", f), 1'b0, 10'd41, 32'd121);
    end

    cyc(3'b000, 4'b0000, 25'd150, 10'd1023, 1, 1, 1, 1);
    outs("nonBranchWrap", 1'b0, 10'd0, 32'd121);

    cyc(3'b010, 4'b1001, 25'd150, 10'd500, 0, 0, 0, 0);
    outs("nonBranchCall", 1'b0, 10'd501, 32'd121);

    cyc(3'b011, 4'b1001, 25'd5, 10'd1023, 0, 0, 0, 0);
    outs("callWrap", 1'b1, 10'd5, 32'd0);

    cyc(3'b011, 4'b1001, 25'd150, 10'd120, 0, 0, 0, 0);
    outs("callAgain", 1'b1, 10'd150, 32'd121);

    #2;
    rst_n = 1'b0;
    #1;
    outs("asyncReset", 1'b0, 10'd0, 32'd0);
    @(posedge clk);
    #1;
    outs("asyncResetHeld", 1'b0, 10'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    outs("afterRelease", 1'b0, 10'd0, 32'd0);
    @(posedge clk);
    #1;
    outs("firstEdge", 1'b1, 10'd150, 32'd121);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Branch-resolution block of the KGP-RISC execute stage. It decodes branch-class instructions (opcode 3'b011) against the ALU status flags and resolves taken/not-taken. It produces the next PC, the PC-select strobe for the fetch mux, and the 32-bit return-address (link) register written by `call`. Outputs are registered: one cycle after the instruction is presented, fetch sees the branch decision.

## Interface
- No parameters. Widths are fixed by the ISA: PC 10 bits, label field 25 bits, link 32 bits.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  3  instruction class; 3'b011 = branch.
- `fcode`  in  4  branch function code.
- `label`  in  25  branch target field; only `label[9:0]` is used, as an absolute target.
- `carryFlag`, `zFlag`, `overflowFlag`, `signFlag`  in  1 each  ALU status flags C, Z, V, S.
- `PC`  in  10  address of the current instruction.
- `exNPC`  out  10  registered next PC.
- `PCSrc`  out  1  registered; 1 = take `exNPC` (branch taken).
- `ra`  out  32  registered return-address (link) register.

## Operation
Branch-condition decode, applied only when `opcode == 3'b011`:
- 0000 `b`: always taken.
- 0001 `bz`: taken if Z.
- 0010 `bnz`: taken if !Z.
- 0011 `bcy`: taken if C.
- 0100 `bncy`: taken if !C.
- 0101 `bs`: taken if S.
- 0110 `bns`: taken if !S.
- 0111 `bv`: taken if V.
- 1000 `bnv`: taken if !V.
- 1001 `call`: always taken; also writes the link register.
- 1010 `blt`: signed less-than; taken if S ^ V.
- 1011–1111: reserved; never taken, no link write.

Target and fall-through:
- Target = `label[9:0]`; `label[24:10]` is ignored.
- Fall-through = `PC + 1`, 10-bit, wraps 1023 → 0.

Per clock edge:
- `PCSrc` <= taken.
- `exNPC` <= taken ? target : fall-through.

Link register:
- On `call`: `ra` <= {22'b0, PC+1}, with the 10-bit wrap applied (PC = 1023 gives ra = 0).
- Otherwise `ra` holds its value.

Non-branch opcodes:
- `PCSrc` <= 0, `exNPC` <= PC+1, `ra` holds.

No flag is ever modified by this block.

## Timing
- Reset (`rst_n` low, asynchronous): `exNPC` = 0, `PCSrc` = 0, `ra` = 0 immediately. They stay there until the first rising edge after `rst_n` deasserts.
- Latency: exactly 1 cycle from inputs sampled at edge N to outputs valid after edge N.
- No handshake; every cycle is a new evaluation. `PCSrc` is high only for a cycle whose sampled instruction branched. Back-to-back taken branches keep `PCSrc` high.
- Inputs are sampled only at the rising edge; glitches between edges are ignored.
- Reset asserted mid-operation: all outputs clear at once, including a pending `PCSrc` pulse and the `ra` contents.
- A `call` at PC = 1023: `exNPC` = target, `ra` = 0.

## Structure
- Shared package `kgp_pkg`:
  - `OP_BRANCH = 3'b011`.
  - `fcode` localparams `FC_B` … `FC_BLT`.
  - `PC_W = 10`.
- Sub-module `branch_cond`: purely combinational. Takes `fcode` + flags and returns `taken` and `is_call`.
- Top level: registers, PC+1 adder, target select.

## Test plan
- Reset, then opcode 011, fcode 1001, label 150, PC 120, V=1, S=1 → after one edge: `PCSrc` = 1, `exNPC` = 150, `ra` = 121.
- Next cycle, fcode 0000, label 150, PC 0 → `PCSrc` = 1, `exNPC` = 150, `ra` stays 121.
- fcode 1010, PC 120, V=1, S=1 → not taken: `PCSrc` = 0, `exNPC` = 121. Same with S=1, V=0 → taken, `exNPC` = 150.
- Sweep fcode 0001–1000 with each flag at 0 and at 1 → taken exactly per the table; `ra` unchanged throughout.
- opcode 000, fcode 0000, PC 1023 → `PCSrc` = 0, `exNPC` = 0. Then fcode 1001, PC 1023, label 5 → `exNPC` = 5, `ra` = 0.
- Assert `rst_n` low between edges while `PCSrc` = 1 and `ra` = 121 → all outputs 0 with no clock edge; they remain 0 until the first edge after release.
